alu_issue_queue: RTL
====================

Name: alu_issue_queue

Overview:
Reservation station that sits directly upstream of the integer ALU in the execute stage. It accepts renamed ALU ops from dispatch, holds them until both source operands are available, and captures operands from the common data bus (CDB). Each cycle it presents the oldest ready op to the ALU (op, a, b, destination tag). It uses a compacting, age-ordered queue: slot 0 always holds the oldest entry.

Parameters:
DEPTH, 4, number of entries (2..16)
TAG_W, 6, physical register / ROB tag width

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
flush_i  in  1  squash all entries (branch mispredict)
disp_valid_i  in  1  dispatch request
disp_ready_o  out  1  queue can accept an entry
disp_op_i  in  alu_op_e  ALU operation (core_types_pkg)
disp_dst_tag_i  in  TAG_W  destination tag
disp_src1_rdy_i  in  1  src1 value valid at dispatch
disp_src1_tag_i  in  TAG_W  src1 producer tag
disp_src1_val_i  in  32  src1 value
disp_src2_rdy_i  in  1  src2 value valid at dispatch
disp_src2_tag_i  in  TAG_W  src2 producer tag
disp_src2_val_i  in  32  src2 value (imm already muxed in by decode)
cdb_valid_i  in  1  result broadcast
cdb_tag_i  in  TAG_W  broadcast tag
cdb_val_i  in  32  broadcast value
iss_valid_o  out  1  issue candidate present
iss_ready_i  in  1  ALU accepts
iss_op_o  out  alu_op_e  op to ALU
iss_a_o  out  32  operand a
iss_b_o  out  32  operand b
iss_dst_tag_o  out  TAG_W  destination tag
count_o  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset: all entries invalid, count_o=0, disp_ready_o=1, iss_valid_o=0. iss_op_o=ALU_ADD, iss_a_o=0, iss_b_o=0, iss_dst_tag_o=0.
- Per-entry state: valid, op, dst_tag, and for each source: rdy, tag, val.
- Dispatch acceptance:
  - disp_ready_o = (count_o < DEPTH) && !flush_i.
  - Driven from registered count only; an issue in the same cycle does not free a slot for dispatch.
  - Accept = disp_valid_i && disp_ready_o.
- Dispatch placement: the new entry is written at the youngest position after any same-cycle compaction. Slot index = count - (issue fired ? 1 : 0).
- Dispatch-cycle wakeup: if cdb_valid_i and cdb_tag_i matches a not-ready dispatching source tag, that source is stored rdy=1 with val=cdb_val_i.
- Wakeup:
  - Each edge, every valid entry with a not-ready source whose tag == cdb_tag_i (cdb_valid_i=1) sets rdy=1 and val=cdb_val_i.
  - Both sources of one entry may wake on the same broadcast.
- Select:
  - Combinational on registered state: the lowest-index (oldest) valid entry with both rdy=1.
  - iss_valid_o=1 if one exists; iss_* outputs carry that entry's fields.
  - With iss_valid_o=0, iss_* outputs are zero.
  - Selection may change while iss_ready_i=0 (an older entry becoming ready preempts). The ALU does not assume stability.
- Issue:
  - Fires when iss_valid_o && iss_ready_i.
  - The selected entry is removed at the edge; entries above it shift down one slot, preserving order.
- Latency:
  - Dispatch with both operands ready in cycle N: issuable in cycle N+1.
  - CDB wakeup in cycle N: issuable in cycle N+1. There is no same-cycle CDB-to-issue bypass.
- count_o: next = count + accept - issue. Dispatch and issue in the same cycle leave it unchanged.
- Full: disp_ready_o=0; disp_valid_i is ignored and the entry is dropped (dispatch must hold it).
- Flush:
  - At the edge with flush_i=1, all entries are invalidated and count_o=0.
  - Any dispatch that cycle is blocked (disp_ready_o=0).
  - iss_valid_o is still driven that cycle from current state; the issue handshake is accepted, but the entry is discarded by the flush.
- Reset mid-operation: asynchronous clear to the reset state regardless of pending handshakes.

Optional Feature:
- Macro: ALU_IQ_PERF_EN.
- Defined:
  - Adds output port full_stall_cnt_o, 32 bits.
  - Counts cycles with disp_valid_i && !disp_ready_o && !flush_i.
  - Saturates at 32'hFFFF_FFFF; reset value 0; not cleared by flush_i.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold rst_n=0 then release -> count_o=0, disp_ready_o=1, iss_valid_o=0, iss_a_o=0.
- Ready dispatch: cycle 0 dispatch ALU_ADD, src1 rdy val 5, src2 rdy val 7, dst 3; iss_ready_i=1 -> cycle 1 iss_valid_o=1, op ALU_ADD, a=5, b=7, dst_tag=3; cycle 2 count_o=0, iss_valid_o=0.
- Wakeup: dispatch ALU_SUB, src1 waiting tag 9, src2 rdy val 1 -> no issue. Next cycle CDB tag 9 val 32'h20 -> following cycle iss_a_o=32'h20, iss_b_o=1.
- Same-cycle dispatch+CDB: dispatch src1 waiting tag 12 while CDB tag 12 val 32'hAB -> entry issues next cycle with a=32'hAB.
- Full and age order (DEPTH=4): dispatch 4 entries waiting on tag 9 (entries 0 and 2) and tag 10 (entries 1 and 3).
  - Fifth dispatch -> disp_ready_o=0, count_o stays 4.
  - CDB tag 9 with iss_ready_i=1 -> entry 0 issues, then entry 2.
  - CDB tag 10 -> entry 1 issues, then entry 3.
- Flush: 3 entries held plus dispatch asserted with flush_i=1 -> next cycle count_o=0, iss_valid_o=0, and no later issue of any flushed dst_tag.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Age-ordered, compacting ALU reservation station: slot 0 is always the oldest entry.
// Optional build macro ALU_IQ_PERF_EN adds a saturating dispatch full-stall cycle counter.
package core_types_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;
endpackage

module alu_issue_queue
  import core_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         disp_valid_i,
  output logic                         disp_ready_o,
  input  alu_op_e                      disp_op_i,
  input  logic [TAG_W-1:0]             disp_dst_tag_i,
  input  logic                         disp_src1_rdy_i,
  input  logic [TAG_W-1:0]             disp_src1_tag_i,
  input  logic [31:0]                  disp_src1_val_i,
  input  logic                         disp_src2_rdy_i,
  input  logic [TAG_W-1:0]             disp_src2_tag_i,
  input  logic [31:0]                  disp_src2_val_i,
  input  logic                         cdb_valid_i,
  input  logic [TAG_W-1:0]             cdb_tag_i,
  input  logic [31:0]                  cdb_val_i,
  output logic                         iss_valid_o,
  input  logic                         iss_ready_i,
  output alu_op_e                      iss_op_o,
  output logic [31:0]                  iss_a_o,
  output logic [31:0]                  iss_b_o,
  output logic [TAG_W-1:0]             iss_dst_tag_o,
`ifdef ALU_IQ_PERF_EN
  output logic [31:0]                  full_stall_cnt_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic             valid;
    alu_op_e          op;
    logic [TAG_W-1:0] dst_tag;
    logic             src1_rdy;
    logic [TAG_W-1:0] src1_tag;
    logic [31:0]      src1_val;
    logic             src2_rdy;
    logic [TAG_W-1:0] src2_tag;
    logic [31:0]      src2_val;
  } entry_t;

  entry_t           ent_q   [DEPTH];
  entry_t           woken   [DEPTH];
  entry_t           shifted [DEPTH];
  entry_t           ent_d   [DEPTH];
  entry_t           sel_ent;
  entry_t           new_ent;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] sel_idx;
  logic [CNT_W-1:0] disp_slot;
  logic             sel_found;
  logic             accept;
  logic             fire;

  // Oldest-first select: scanning from the top down lets the lowest ready index win.
  always_comb begin
    // NOTE: every comb output gets a default before any conditional assignment so no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_ent   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = CNT_W'(i);
        sel_ent   = ent_q[i];
      end
    end
  end

  // sel_ent is all-zero when nothing is ready, which yields ALU_ADD / zero operands.
  assign iss_valid_o   = sel_found;
  assign iss_op_o      = sel_ent.op;
  assign iss_a_o       = sel_ent.src1_val;
  assign iss_b_o       = sel_ent.src2_val;
  assign iss_dst_tag_o = sel_ent.dst_tag;

  assign disp_ready_o = (count_q < CNT_W'(DEPTH)) && !flush_i;
  assign accept       = disp_valid_i && disp_ready_o;
  assign fire         = sel_found && iss_ready_i;
  assign disp_slot    = count_q - CNT_W'(fire);
  assign count_o      = count_q;

  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.op       = disp_op_i;
    new_ent.dst_tag  = disp_dst_tag_i;
    new_ent.src1_rdy = disp_src1_rdy_i;
    new_ent.src1_tag = disp_src1_tag_i;
    new_ent.src1_val = disp_src1_val_i;
    new_ent.src2_rdy = disp_src2_rdy_i;
    new_ent.src2_tag = disp_src2_tag_i;
    new_ent.src2_val = disp_src2_val_i;
    // A producer broadcasting in the dispatch cycle would otherwise be missed forever.
    if (cdb_valid_i && !disp_src1_rdy_i && disp_src1_tag_i == cdb_tag_i) begin
      new_ent.src1_rdy = 1'b1;
      new_ent.src1_val = cdb_val_i;
    end
    if (cdb_valid_i && !disp_src2_rdy_i && disp_src2_tag_i == cdb_tag_i) begin
      new_ent.src2_rdy = 1'b1;
      new_ent.src2_val = cdb_val_i;
    end
  end

  // Next state: wake on CDB, close the gap left by an issue, append dispatch, then flush.
  always_comb begin
    // NOTE: blocking assignments here build the result in stages within one evaluation.
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = ent_q[i];
      if (cdb_valid_i && ent_q[i].valid && !ent_q[i].src1_rdy &&
          ent_q[i].src1_tag == cdb_tag_i) begin
        woken[i].src1_rdy = 1'b1;
        woken[i].src1_val = cdb_val_i;
      end
      if (cdb_valid_i && ent_q[i].valid && !ent_q[i].src2_rdy &&
          ent_q[i].src2_tag == cdb_tag_i) begin
        woken[i].src2_rdy = 1'b1;
        woken[i].src2_val = cdb_val_i;
      end
    end

    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = woken[i+1];
    end
    shifted[DEPTH-1] = '0;

    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (fire && CNT_W'(i) >= sel_idx) ? shifted[i] : woken[i];
      if (accept && CNT_W'(i) == disp_slot) begin
        ent_d[i] = new_ent;
      end
      if (flush_i) begin
        ent_d[i] = '0;
      end
    end

    count_d = flush_i ? '0 : count_q + CNT_W'(accept) - CNT_W'(fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the entry array is reset in full; valid bits must clear, and clearing payload keeps outputs zero.
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for all registered state.
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
    end
  end

`ifdef ALU_IQ_PERF_EN
  // Counts cycles where dispatch is held off by a full queue; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_stall_cnt_o <= '0;
    end else if (disp_valid_i && !disp_ready_o && !flush_i && full_stall_cnt_o != 32'hFFFF_FFFF) begin
      full_stall_cnt_o <= full_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
